arrow_dir_queue: RTL and testbench

// - Conditions the four arrow buttons for the snake game core and queues turn requests.
// - Synchronises, debounces and edge-detects the buttons, then rejects reversals and duplicates.
// - Buffers accepted turns in a small FIFO; the game tick pops one per step. Output cur_dir feeds the core's move logic.
// - Also supplies a press-timing-mixed LFSR seed for apple placement.

---
 rtl/arrow_dir_queue_if.sv | 20 ++
 rtl/arrow_dir_queue.sv | 117 +++++++++++
 tb/tb_arrow_dir_queue.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/arrow_dir_queue_if.sv
// arrow_dir_queue_if: button inputs, turn-pop strobe and direction/seed outputs of the arrow queue.
interface arrow_dir_queue_if;
    logic        arrow_up;
    logic        arrow_down;
    logic        arrow_left;
    logic        arrow_right;
    logic        dir_pop;
    logic [1:0]  cur_dir;
    logic [3:0]  q_count;
    logic        press_drop;
    logic [15:0] seed;
    modport master (
        output arrow_up, arrow_down, arrow_left, arrow_right, dir_pop,
        input  cur_dir, q_count, press_drop, seed
    );
    modport slave (
        input  arrow_up, arrow_down, arrow_left, arrow_right, dir_pop,
        output cur_dir, q_count, press_drop, seed
    );
endinterface

// File: rtl/arrow_dir_queue.sv
// arrow_dir_queue: conditions arrow buttons, filters and queues turns, commits on dir_pop, mixes an LFSR seed.
// ARROW_DEBOUNCE_EN defined builds per-button debounce counters; undefined passes synced levels straight through.
module arrow_dir_queue #(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int DEPTH           = 2
) (
    input logic              clk,
    input logic              reset,
    arrow_dir_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEBOUNCE_CYCLES < 2 || DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("arrow_dir_queue: unsupported DEBOUNCE_CYCLES/DEPTH");
    end

    // Bit index equals direction code: 0 up, 1 down, 2 left, 3 right.
    logic [3:0]  raw, s1_q, s2_q, sync_p, stable, prev_q, evt;
    logic [1:0]  cand, ref_dir, cur_q;
    logic [1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [3:0]  count_q, count_d;
    logic [15:0] seed_q, seed_d, lfsr_next, seed_mix;
    logic        has_evt, multi, full, reject, push, pop, drop, drop_q;

    assign raw    = {bus.arrow_right, bus.arrow_left, bus.arrow_down, bus.arrow_up};
    assign sync_p = s2_q ^ 4'b0011;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 4'b0011;
            s2_q <= 4'b0011;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

`ifdef ARROW_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [CW-1:0] cnt_q [4];
    logic [3:0]    stable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q[i] <= sync_p[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync_p;
`endif

    assign evt = stable & ~prev_q;

    // Only the highest-priority press is a candidate; any extra presses count as drops.
    always_comb begin
        has_evt   = |evt;
        multi     = (evt & (evt - 4'd1)) != 4'd0;
        cand      = evt[0] ? 2'd0 : evt[1] ? 2'd1 : evt[2] ? 2'd2 : 2'd3;
        ref_dir   = (count_q != 4'd0) ? mem_q[wr_q - 1'b1] : cur_q;
        full      = count_q == 4'(DEPTH);
        reject    = cand == ref_dir || cand == {ref_dir[1], ~ref_dir[0]} || (full && !bus.dir_pop);
        push      = has_evt && !reject;
        pop       = bus.dir_pop && count_q != 4'd0;
        drop      = multi || (has_evt && reject);
        count_d   = count_q + {3'b0, push} - {3'b0, pop};
        lfsr_next = {1'b0, seed_q[15:1]} ^ (seed_q[0] ? 16'hB400 : 16'h0000);
        seed_mix  = push ? lfsr_next ^ {14'b0, cand} : lfsr_next;
        seed_d    = (seed_mix == 16'h0000) ? 16'hACE1 : seed_mix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            cur_q   <= 2'd1;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            drop_q  <= 1'b0;
            seed_q  <= 16'hACE1;
        end else begin
            prev_q  <= stable;
            count_q <= count_d;
            drop_q  <= drop;
            seed_q  <= seed_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                cur_q <= mem_q[rd_q];
                rd_q  <= rd_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= cand;
    end

    assign bus.cur_dir    = cur_q;
    assign bus.q_count    = count_q;
    assign bus.press_drop = drop_q;
    assign bus.seed       = seed_q;
endmodule

// File: tb/tb_arrow_dir_queue.sv
// tb_arrow_dir_queue: directed scenarios plus random button/pop traffic against a queue-based reference model.
module tb_arrow_dir_queue;
    localparam int DB    = 4;
    localparam int DEPTH = 2;
`ifdef ARROW_DEBOUNCE_EN
    localparam bit DBEN = 1'b1;
    localparam int LAT  = DB + 3;
`else
    localparam bit DBEN = 1'b0;
    localparam int LAT  = 3;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    arrow_dir_queue_if bus();

    arrow_dir_queue #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int drops   = 0;

    // Reference state: pressed levels per direction code, FIFO as a queue.
    bit [3:0]    m_s1, m_s2, m_stb, m_prev;
    int          m_run [4];
    int          m_q [$];
    int          m_cur;
    bit          m_drop;
    logic [15:0] m_seed;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_s1   = '0;
        m_s2   = '0;
        m_stb  = '0;
        m_prev = '0;
        for (int d = 0; d < 4; d++) m_run[d] = 0;
        m_q.delete();
        m_cur  = 1;
        m_drop = 1'b0;
        m_seed = 16'hACE1;
    endfunction

    function automatic void m_step(input bit [3:0] p, input bit pop);
        bit [3:0]    lvl = DBEN ? m_stb : m_s2;
        bit [3:0]    evt = lvl & ~m_prev;
        int          cand = -1;
        int          nev = 0;
        int          rf;
        bit          rej;
        bit          psh;
        logic [15:0] nx;
        for (int d = 0; d < 4; d++) if (evt[d]) begin
            nev++;
            if (cand < 0) cand = d;
        end
        rf     = (m_q.size() > 0) ? m_q[$] : m_cur;
        rej    = nev > 0 && (cand == rf || cand == (rf ^ 1) || (m_q.size() == DEPTH && !pop));
        psh    = nev > 0 && !rej;
        m_drop = nev > 1 || rej;
        nx = (m_seed >> 1) ^ (m_seed[0] ? 16'hB400 : 16'h0000);
        if (psh) nx = nx ^ 16'(cand);
        m_seed = (nx == 16'h0000) ? 16'hACE1 : nx;
        if (pop && m_q.size() > 0) m_cur = m_q.pop_front();
        if (psh) m_q.push_back(cand);
        m_prev = lvl;
        // A level change is accepted once it has persisted for DB consecutive cycles.
        for (int d = 0; d < 4; d++) begin
            if (m_s2[d] != m_stb[d]) begin
                m_run[d]++;
                if (m_run[d] == DB) begin
                    m_stb[d] = m_s2[d];
                    m_run[d] = 0;
                end
            end else begin
                m_run[d] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = p;
    endfunction

    task automatic cycle(input bit [3:0] p, input bit pop);
        bus.arrow_up    = ~p[0];
        bus.arrow_down  = ~p[1];
        bus.arrow_left  = p[2];
        bus.arrow_right = p[3];
        bus.dir_pop     = pop;
        @(posedge clk);
        m_step(p, pop);
        #1;
        chk("cur_dir", 32'(bus.cur_dir), 32'(m_cur));
        chk("q_count", 32'(bus.q_count), 32'(m_q.size()));
        chk("press_drop", 32'(bus.press_drop), 32'(m_drop));
        chk("seed", 32'(bus.seed), 32'(m_seed));
        drops += int'(bus.press_drop);
    endtask

    task automatic press(input bit [3:0] p);
        repeat (8) cycle(p, 1'b0);
        repeat (8) cycle(4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        cycle(4'b0000, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        int d0;
        bus.arrow_up    = 1'b1;
        bus.arrow_down  = 1'b1;
        bus.arrow_left  = 1'b0;
        bus.arrow_right = 1'b0;
        bus.dir_pop     = 1'b0;
        m_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_cur_dir", 32'(bus.cur_dir), 32'd1);
        chk("rst_q_count", 32'(bus.q_count), 32'd0);
        chk("rst_press_drop", 32'(bus.press_drop), 32'd0);
        chk("rst_seed", 32'(bus.seed), 32'hACE1);
        @(posedge clk);
        #1 reset = 1'b0;

        repeat (20) cycle(4'b0000, 1'b0);
        chk("idle_seed_nz", 32'(bus.seed != 16'h0), 32'd1);
        chk("idle_drops", 32'(drops), 32'd0);

        repeat (10) cycle(4'b1000, 1'b0);
        chk("right_push", 32'(bus.q_count), 32'd1);
        cycle(4'b0000, 1'b1);
        chk("right_commit", 32'(bus.cur_dir), 32'd3);
        chk("right_empty", 32'(bus.q_count), 32'd0);
        repeat (10) cycle(4'b0000, 1'b0);

        repeat (3) cycle(4'b0100, 1'b0);
        repeat (12) cycle(4'b0000, 1'b0);

        do_reset();
        d0 = drops;
        press(4'b0001);
        chk("opp_drop", 32'(drops - d0), 32'd1);
        chk("opp_q", 32'(bus.q_count), 32'd0);
        d0 = drops;
        press(4'b0010);
        chk("dup_drop", 32'(drops - d0), 32'd1);
        chk("dup_q", 32'(bus.q_count), 32'd0);

        press(4'b0100);
        press(4'b0001);
        chk("fill_q", 32'(bus.q_count), 32'd2);
        d0 = drops;
        press(4'b1000);
        chk("full_drop", 32'(drops - d0), 32'd1);
        for (int i = 0; i < LAT; i++) cycle(4'b1000, i == LAT - 1);
        chk("full_pop_cur", 32'(bus.cur_dir), 32'd2);
        chk("full_pop_q", 32'(bus.q_count), 32'd2);
        repeat (8) cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        chk("head_up", 32'(bus.cur_dir), 32'd0);
        cycle(4'b0000, 1'b1);
        chk("head_right", 32'(bus.cur_dir), 32'd3);
        chk("drained_q", 32'(bus.q_count), 32'd0);

        press(4'b0001);
        press(4'b0100);
        chk("pre_rst_q", 32'(bus.q_count), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_cur_dir", 32'(bus.cur_dir), 32'd1);
        chk("async_q_count", 32'(bus.q_count), 32'd0);
        chk("async_seed", 32'(bus.seed), 32'hACE1);
        chk("async_drop", 32'(bus.press_drop), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();

        repeat (150) begin
            bit [3:0] p;
            int       n;
            p = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 10);
            repeat (n) cycle(p, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
